// File: rtl/sram_array_1p_wipe_if.sv
// Request/grant access bus of the self-wiping single-port SRAM array.
// The array is the slave; the memory controller or ECC wrapper is the master.
interface sram_array_1p_wipe_if #(
  parameter int unsigned Width     = 39,
  parameter int unsigned MaskWidth = 1,
  parameter int unsigned AddrWidth = 10
);
  logic                 req_i;
  logic                 gnt_o;
  logic                 write_i;
  logic [AddrWidth-1:0] addr_i;
  logic [MaskWidth-1:0] wmask_i;
  logic [Width-1:0]     wdata_i;
  logic                 rvalid_o;
  logic [Width-1:0]     rdata_o;

  modport master (
    output req_i, write_i, addr_i, wmask_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, write_i, addr_i, wmask_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/sram_array_1p_wipe.sv
// Width/depth-generic single-port SRAM with active-low grouped write mask,
// one-cycle read latency and a wipe engine that zeroizes every word after reset or on request.
module sram_array_1p_wipe #(
  parameter  int unsigned Depth           = 1024,
  parameter  int unsigned Width           = 39,
  parameter  int unsigned DataBitsPerMask = 39,
  localparam int unsigned MaskWidth       = Width / DataBitsPerMask,
  localparam int unsigned AddrWidth       = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sram_array_1p_wipe_if.slave  bus,
  input  logic                 wipe_i,
  output logic                 init_done_o
);

  if ((Width % DataBitsPerMask) != 0) begin : g_bad_mask_width
    $error("Width must be a multiple of DataBitsPerMask");
  end
  if (Depth < 2) begin : g_bad_depth
    $error("Depth must be at least 2");
  end

  localparam logic [AddrWidth:0]   DepthExt = (AddrWidth + 1)'(Depth);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

  typedef enum logic {
    StWipe = 1'b0,
    StIdle = 1'b1
  } state_e;

  state_e               state_q;
  logic [AddrWidth-1:0] cnt_q;
  logic                 gnt_q;
  logic                 init_done_q;
  logic                 rvalid_q;
  logic [Width-1:0]     rdata_q;

  logic [Width-1:0]     mem_q [Depth];

  logic                 in_range_s;
  logic                 mem_we_s;
  logic [AddrWidth-1:0] mem_addr_s;
  logic [Width-1:0]     mem_wdata_s;
  logic [MaskWidth-1:0] mem_gen_s;

  assign in_range_s = ({1'b0, bus.addr_i} < DepthExt);

  // Single memory write port shared by the wipe engine and accepted writes.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    mem_gen_s   = '0;
    case (state_q)
      StWipe: begin
        mem_we_s   = 1'b1;
        mem_addr_s = cnt_q;
        mem_gen_s  = '1;
      end
      StIdle: begin
        // Out-of-range writes are dropped rather than aliased onto a real word.
        if (bus.req_i && bus.write_i && in_range_s) begin
          mem_we_s    = 1'b1;
          mem_addr_s  = bus.addr_i;
          mem_wdata_s = bus.wdata_i;
          mem_gen_s   = ~bus.wmask_i;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Storage array; contents are deliberately not reset, the wipe engine clears them.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      for (int g = 0; g < int'(MaskWidth); g++) begin
        if (mem_gen_s[g]) begin
          mem_q[mem_addr_s][g*DataBitsPerMask +: DataBitsPerMask] <=
            mem_wdata_s[g*DataBitsPerMask +: DataBitsPerMask];
        end
      end
    end
  end

  // Wipe/idle FSM with registered grant, init-done and read-return outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StWipe;
      cnt_q       <= '0;
      gnt_q       <= 1'b0;
      init_done_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        StWipe: begin
          if (cnt_q == LastAddr) begin
            cnt_q       <= '0;
            state_q     <= StIdle;
            gnt_q       <= 1'b1;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + AddrWidth'(1);
          end
        end
        StIdle: begin
          if (bus.req_i && !bus.write_i) begin
            rvalid_q <= 1'b1;
            rdata_q  <= in_range_s ? mem_q[bus.addr_i] : '0;
          end
          // An access accepted alongside wipe_i completes first; the wipe then overwrites it.
          if (wipe_i) begin
            state_q     <= StWipe;
            cnt_q       <= '0;
            gnt_q       <= 1'b0;
            init_done_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StWipe;
          cnt_q       <= '0;
          gnt_q       <= 1'b0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_o    = gnt_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign init_done_o  = init_done_q;

endmodule

// File: doc/sram_array_1p_wipe.md
# sram_array_1p_wipe

Parametrised single-port synchronous SRAM array with grouped write masking, a request/grant handshake, an explicit read-valid strobe and a hardware wipe engine. After reset, or on request, the wipe engine zeroizes every word. It is the next-generation, width/depth-generic replacement for the fixed 1024x39 single-port arrays in the zgc_ip_sram library. It sits between a memory controller or ECC wrapper and the storage, and guarantees no stale data survives reset or a wipe.

## Interface
- Depth, 1024: number of words (any value >= 2, need not be a power of two)
- Width, 39: word width in bits
- DataBitsPerMask, 39: bits per write-mask group; Width % DataBitsPerMask must be 0, otherwise elaboration fails
- MaskWidth, Width/DataBitsPerMask: derived; number of mask groups
- AddrWidth, $clog2(Depth): derived

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- req_i  input  1  access request
- gnt_o  output  1  request accepted this cycle (combinational from state only, never from req_i)
- write_i  input  1  1 = write, 0 = read; sampled with req_i
- addr_i  input  AddrWidth  word address
- wmask_i  input  MaskWidth  active-low per-group write mask: bit g = 0 writes group g, bit g = 1 preserves it
- wdata_i  input  Width  write data
- rvalid_o  output  1  one-cycle strobe: rdata_o carries the read result
- rdata_o  output  Width  read data, held between reads
- wipe_i  input  1  request full zeroization, level-sampled
- init_done_o  output  1  high when the array is idle and accessible (not wiping)

## Operation
- Two-state FSM: WIPE and IDLE. Reset enters WIPE with the wipe counter at 0.
- WIPE:
  - Each cycle writes all-zeros to mem[counter], then increments the counter.
  - When the counter equals Depth-1, the write completes, the counter clears and the FSM goes to IDLE.
  - gnt_o = 0 and init_done_o = 0 throughout; req_i is ignored and the requester holds its request.
  - wipe_i is ignored, so a wipe is not restarted.
- IDLE:
  - gnt_o = 1 and init_done_o = 1.
  - A cycle with req_i && gnt_o is an accepted access.
  - wipe_i = 1 moves the FSM to WIPE at the next edge. If req_i is also high in that cycle, the access is still accepted and completes first, so the wipe overwrites it.
- Write:
  - For each group g with wmask_i[g] = 0, mem[addr_i][g*DataBitsPerMask +: DataBitsPerMask] takes the matching wdata_i slice.
  - Other groups are unchanged. An all-ones mask is a legal no-op write.
  - rvalid_o is not asserted for writes.
- Read: rdata_o <= mem[addr_i]; rvalid_o = 1 for exactly the following cycle.
- Out-of-range address (addr_i >= Depth): writes are discarded; reads return all-zeros with a normal rvalid_o.
- rdata_o changes only on an accepted read; wipe does not clear rdata_o.

## Timing
- Reset values: gnt_o = 0, init_done_o = 0, rvalid_o = 0, rdata_o = 0, FSM = WIPE, counter = 0. Reset is asynchronous; assertion mid-wipe or mid-read aborts immediately.
- Wipe duration: exactly Depth cycles. With edge 1 as the first rising edge after rst_ni is released, gnt_o/init_done_o rise after edge Depth and are high in cycle Depth+1.
- Read latency: 1. A read accepted at edge N gives rvalid_o high and valid rdata_o between edges N and N+1.
- Back-to-back accesses are allowed every cycle. A read at N followed by a write to the same address at N+1 returns the old data. A write at N followed by a read at N+1 returns the new data.
- wipe_i sampled high at edge N in IDLE: gnt_o drops after N. The rvalid_o of a read accepted at N still asserts in the next cycle.
- Memory contents have no reset; only the wipe engine initializes them.

## Test plan
- Reset release with Depth=16, Width=39: gnt_o/init_done_o rise exactly 16 cycles after release; reading addresses 0..15 returns 0, each with a single rvalid_o pulse.
- Width=32, DataBitsPerMask=8: write 0xAABBCCDD to addr 5 with mask 4'b0000, then 0x11223344 with mask 4'b1010; read returns 0xAA22CC44 one cycle after grant.
- Write 0x5 then read addr 3 on consecutive cycles: read returns 0x5. Read then write on consecutive cycles: read returns the prior value.
- Depth=12: write to addr 13 leaves the memory unchanged; read of addr 13 returns 0 with rvalid_o.
- Fill all words with 0x7F, then pulse wipe_i together with a read of addr 2: rvalid_o returns 0x7F, gnt_o stays low for Depth cycles, and all later reads return 0.
- Assert rst_ni low mid-wipe (counter=7): outputs return to their reset values immediately, and a full Depth-cycle wipe restarts from 0.
